// File: rtl/hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_pkg
// Shared constants for the pipeline hazard/forwarding controller:
//   - bypass select encodings (FWD_REG / FWD_MEM / FWD_WB)
//   - controller FSM state encoding (hz_state_e)
//   - width of the internal stall/flush length counter and a helper that
//     converts a configured cycle count into the counter reload value.
// -----------------------------------------------------------------------------
package hazard_ctrl_pkg;

  // Execute-stage operand bypass selects
  localparam logic [1:0] FWD_REG = 2'b00;  // register file value
  localparam logic [1:0] FWD_MEM = 2'b01;  // memory-stage result
  localparam logic [1:0] FWD_WB  = 2'b10;  // writeback-stage result

  // Holds LOAD_STALL_CYC (<= 7) and FLUSH_CYC (<= 3) remaining-cycle counts
  localparam int CYC_W = 3;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'b00,
    HZ_LD_STALL = 2'b01,
    HZ_MC_STALL = 2'b10,
    HZ_FLUSH    = 2'b11
  } hz_state_e;

  // The first stall/flush cycle is produced combinationally, so the state
  // counter only has to cover the remaining cyc-1 cycles.
  function automatic logic [CYC_W-1:0] hold_len(input int cyc);
    return CYC_W'(cyc - 1);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_if
// Bundle between the pipeline datapath and the hazard controller.
//   master : pipeline side, drives stage register indices / control flags and
//            receives bypass selects, stall/flush controls and counters.
//   slave  : hazard controller side.
// Signals:
//   rs1_de, rs2_de, rs1_ex, rs2_ex, rd_ex, rd_me, rd_wb : register indices
//   mem_read_ex, reg_write_me, mem_read_me, reg_write_wb : stage control
//   pc_r    : execute resolved a taken redirect
//   ex_busy : multi-cycle execute unit still working
//   fwd_rs1, fwd_rs2 : bypass selects for the execute operands
//   stall_fe/de/ex, flush_de/ex, redirect_take : pipeline controls
//   stall_cnt, flush_cnt : performance counters (zero unless enabled)
// -----------------------------------------------------------------------------
interface hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
);

  logic [REG_ADDR_W-1:0] rs1_de;
  logic [REG_ADDR_W-1:0] rs2_de;
  logic [REG_ADDR_W-1:0] rs1_ex;
  logic [REG_ADDR_W-1:0] rs2_ex;
  logic [REG_ADDR_W-1:0] rd_ex;
  logic                  mem_read_ex;
  logic [REG_ADDR_W-1:0] rd_me;
  logic                  reg_write_me;
  logic                  mem_read_me;
  logic [REG_ADDR_W-1:0] rd_wb;
  logic                  reg_write_wb;
  logic                  pc_r;
  logic                  ex_busy;

  logic [1:0]            fwd_rs1;
  logic [1:0]            fwd_rs2;
  logic                  stall_fe;
  logic                  stall_de;
  logic                  stall_ex;
  logic                  flush_de;
  logic                  flush_ex;
  logic                  redirect_take;
  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      flush_cnt;

  modport master (
    output rs1_de, rs2_de, rs1_ex, rs2_ex, rd_ex, mem_read_ex,
           rd_me, reg_write_me, mem_read_me, rd_wb, reg_write_wb,
           pc_r, ex_busy,
    input  fwd_rs1, fwd_rs2, stall_fe, stall_de, stall_ex,
           flush_de, flush_ex, redirect_take, stall_cnt, flush_cnt
  );

  modport slave (
    input  rs1_de, rs2_de, rs1_ex, rs2_ex, rd_ex, mem_read_ex,
           rd_me, reg_write_me, mem_read_me, rd_wb, reg_write_wb,
           pc_r, ex_busy,
    output fwd_rs1, fwd_rs2, stall_fe, stall_de, stall_ex,
           flush_de, flush_ex, redirect_take, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_fwd_sel.sv
// -----------------------------------------------------------------------------
// hazard_fwd_sel
// Combinational bypass comparator for one execute-stage source operand.
// Ports:
//   rs_ex        : source register of the execute-stage instruction
//   rd_me        : memory-stage destination, reg_write_me / mem_read_me flags
//   rd_wb        : writeback-stage destination, reg_write_wb flag
//   fwd_sel      : FWD_MEM, FWD_WB or FWD_REG
// A load in the memory stage has no result yet, so it never bypasses; the
// memory stage wins over writeback because it holds the younger value.
// -----------------------------------------------------------------------------
module hazard_fwd_sel
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs_ex,
  input  logic [REG_ADDR_W-1:0] rd_me,
  input  logic                  reg_write_me,
  input  logic                  mem_read_me,
  input  logic [REG_ADDR_W-1:0] rd_wb,
  input  logic                  reg_write_wb,
  output logic [1:0]            fwd_sel
);

  localparam logic [REG_ADDR_W-1:0] X0 = {REG_ADDR_W{1'b0}};

  // Select the youngest producer of rs_ex, ignoring x0
  always_comb begin
    fwd_sel = FWD_REG;
    if (reg_write_me && !mem_read_me && (rd_me != X0) && (rs_ex == rd_me)) begin
      fwd_sel = FWD_MEM;
    end else if (reg_write_wb && (rd_wb != X0) && (rs_ex == rd_wb)) begin
      fwd_sel = FWD_WB;
    end else begin
      fwd_sel = FWD_REG;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Hazard and forwarding controller for the 5-stage in-order pipeline.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-low reset; all outputs read 0 while low
//   hz  : hazard_ctrl_if.slave bundle (stage indices/flags in, bypass
//         selects, stall/flush/redirect controls and counters out)
// Parameters: REG_ADDR_W, LOAD_STALL_CYC (1..7), FLUSH_CYC (1..3), CNT_W.
// Optional feature macro: HAZARD_PERF_EN -- when defined, stall_cnt counts
// stall_fe cycles and flush_cnt counts flush_de cycles (saturating); when
// undefined no counter flops exist and both read 0.
//
// Event priority each cycle: ex_busy > redirect (pc_r or a pending redirect
// released after busy) > ongoing FLUSH/LD_STALL > new load-use hazard.
// The first cycle of every reaction is combinational; the FSM only covers
// the remaining cycles, tracked by cnt_r.
// -----------------------------------------------------------------------------
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W     = 5,
  parameter int LOAD_STALL_CYC = 1,
  parameter int FLUSH_CYC      = 1,
  parameter int CNT_W          = 32
) (
  input  logic        clk,
  input  logic        rst,
  hazard_ctrl_if.slave hz
);

  localparam logic [CYC_W-1:0] LD_LEN  = hold_len(LOAD_STALL_CYC);
  localparam logic [CYC_W-1:0] FL_LEN  = hold_len(FLUSH_CYC);
  localparam logic [CYC_W-1:0] CYC_ONE = CYC_W'(1);
  localparam logic [REG_ADDR_W-1:0] X0 = {REG_ADDR_W{1'b0}};

  hz_state_e        state_r;
  hz_state_e        nxt_state_s;
  logic [CYC_W-1:0] cnt_r;
  logic [CYC_W-1:0] nxt_cnt_s;
  logic             pend_r;
  logic             nxt_pend_s;

  logic       load_use_s;
  logic [1:0] fwd_rs1_s;
  logic [1:0] fwd_rs2_s;
  logic       stall_fe_s;
  logic       stall_de_s;
  logic       stall_ex_s;
  logic       flush_de_s;
  logic       flush_ex_s;
  logic       redirect_s;

  hazard_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
    .rs_ex        (hz.rs1_ex),
    .rd_me        (hz.rd_me),
    .reg_write_me (hz.reg_write_me),
    .mem_read_me  (hz.mem_read_me),
    .rd_wb        (hz.rd_wb),
    .reg_write_wb (hz.reg_write_wb),
    .fwd_sel      (fwd_rs1_s)
  );

  hazard_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
    .rs_ex        (hz.rs2_ex),
    .rd_me        (hz.rd_me),
    .reg_write_me (hz.reg_write_me),
    .mem_read_me  (hz.mem_read_me),
    .rd_wb        (hz.rd_wb),
    .reg_write_wb (hz.reg_write_wb),
    .fwd_sel      (fwd_rs2_s)
  );

  assign load_use_s = hz.mem_read_ex && (hz.rd_ex != X0) &&
                      ((hz.rd_ex == hz.rs1_de) || (hz.rd_ex == hz.rs2_de));

  // Pipeline controls for this cycle and the FSM successor state
  always_comb begin
    stall_fe_s  = 1'b0;
    stall_de_s  = 1'b0;
    stall_ex_s  = 1'b0;
    flush_de_s  = 1'b0;
    flush_ex_s  = 1'b0;
    redirect_s  = 1'b0;
    nxt_state_s = HZ_RUN;
    nxt_cnt_s   = cnt_r;
    nxt_pend_s  = pend_r;
    if (hz.ex_busy) begin
      // Freeze the front of the pipe; a redirect seen now is remembered
      stall_fe_s  = 1'b1;
      stall_de_s  = 1'b1;
      stall_ex_s  = 1'b1;
      nxt_state_s = HZ_MC_STALL;
      nxt_pend_s  = pend_r | hz.pc_r;
    end else if (hz.pc_r || ((state_r == HZ_MC_STALL) && pend_r)) begin
      // Redirect (live or released after busy) also aborts any load stall
      flush_de_s = 1'b1;
      flush_ex_s = 1'b1;
      redirect_s = 1'b1;
      nxt_pend_s = 1'b0;
      if (FLUSH_CYC > 1) begin
        nxt_state_s = HZ_FLUSH;
        nxt_cnt_s   = FL_LEN;
      end else begin
        nxt_state_s = HZ_RUN;
      end
    end else begin
      case (state_r)
        HZ_FLUSH: begin
          flush_de_s = 1'b1;
          flush_ex_s = 1'b1;
          if (cnt_r == CYC_ONE) begin
            nxt_state_s = HZ_RUN;
          end else begin
            nxt_state_s = HZ_FLUSH;
            nxt_cnt_s   = cnt_r - CYC_ONE;
          end
        end
        HZ_LD_STALL: begin
          stall_fe_s = 1'b1;
          stall_de_s = 1'b1;
          flush_ex_s = 1'b1;
          if (cnt_r == CYC_ONE) begin
            nxt_state_s = HZ_RUN;
          end else begin
            nxt_state_s = HZ_LD_STALL;
            nxt_cnt_s   = cnt_r - CYC_ONE;
          end
        end
        default: begin
          // RUN, or MC_STALL leaving busy without a pending redirect
          if (load_use_s) begin
            stall_fe_s = 1'b1;
            stall_de_s = 1'b1;
            flush_ex_s = 1'b1;
            if (LOAD_STALL_CYC > 1) begin
              nxt_state_s = HZ_LD_STALL;
              nxt_cnt_s   = LD_LEN;
            end else begin
              nxt_state_s = HZ_RUN;
            end
          end else begin
            nxt_state_s = HZ_RUN;
          end
        end
      endcase
    end
  end

  // Controller state, remaining-cycle counter and pending redirect flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= HZ_RUN;
      cnt_r   <= {CYC_W{1'b0}};
      pend_r  <= 1'b0;
    end else begin
      state_r <= nxt_state_s;
      cnt_r   <= nxt_cnt_s;
      pend_r  <= nxt_pend_s;
    end
  end

  // Outputs are forced low for the whole time reset is asserted
  assign hz.fwd_rs1       = rst ? fwd_rs1_s : FWD_REG;
  assign hz.fwd_rs2       = rst ? fwd_rs2_s : FWD_REG;
  assign hz.stall_fe      = rst & stall_fe_s;
  assign hz.stall_de      = rst & stall_de_s;
  assign hz.stall_ex      = rst & stall_ex_s;
  assign hz.flush_de      = rst & flush_de_s;
  assign hz.flush_ex      = rst & flush_ex_s;
  assign hz.redirect_take = rst & redirect_s;

`ifdef HAZARD_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;

  // Saturating counts of stall_fe and flush_de cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (stall_fe_s && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (flush_de_s && (flush_cnt_r != CNT_MAX)) begin
        flush_cnt_r <= flush_cnt_r + CNT_ONE;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign hz.stall_cnt = stall_cnt_r;
  assign hz.flush_cnt = flush_cnt_r;
`else
  assign hz.stall_cnt = {CNT_W{1'b0}};
  assign hz.flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Self-checking bench for hazard_ctrl (LOAD_STALL_CYC=2, FLUSH_CYC=2).
// Directed scenarios followed by randomized cycles, every cycle compared
// against a reference model built from remaining-cycle counts.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam int RW  = 5;
  localparam int LSC = 2;
  localparam int FC  = 2;
  localparam int CW  = 32;

  logic clk;
  logic rst;

  hazard_ctrl_if #(.REG_ADDR_W(RW), .CNT_W(CW)) bus ();

  hazard_ctrl #(
    .REG_ADDR_W     (RW),
    .LOAD_STALL_CYC (LSC),
    .FLUSH_CYC      (FC),
    .CNT_W          (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  int              m_ld_left;
  int              m_fl_left;
  bit              m_pend;
  bit              m_in_mc;
  longint unsigned m_scnt;
  longint unsigned m_fcnt;
  // Model outputs and successor state
  logic [1:0] e_f1, e_f2;
  logic       e_sfe, e_sde, e_sex, e_fde, e_fex, e_rt;
  int         n_ld_left, n_fl_left;
  bit         n_pend, n_in_mc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [RW-1:0] rs);
    if (bus.reg_write_me && !bus.mem_read_me && bus.rd_me != 5'd0 && rs == bus.rd_me) return 2'b01;
    if (bus.reg_write_wb && bus.rd_wb != 5'd0 && rs == bus.rd_wb) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_ld_left = 0; m_fl_left = 0; m_pend = 1'b0; m_in_mc = 1'b0;
    m_scnt = 0; m_fcnt = 0;
  endtask

  task automatic model_eval();
    bit lu;
    {e_sfe, e_sde, e_sex, e_fde, e_fex, e_rt} = 6'b0;
    e_f1 = 2'b00; e_f2 = 2'b00;
    n_ld_left = m_ld_left; n_fl_left = m_fl_left; n_pend = m_pend; n_in_mc = 1'b0;
    if (rst) begin
      e_f1 = ref_fwd(bus.rs1_ex);
      e_f2 = ref_fwd(bus.rs2_ex);
      lu = bus.mem_read_ex && bus.rd_ex != 5'd0 &&
           (bus.rd_ex == bus.rs1_de || bus.rd_ex == bus.rs2_de);
      if (bus.ex_busy) begin
        e_sfe = 1'b1; e_sde = 1'b1; e_sex = 1'b1;
        n_pend = m_pend | bus.pc_r; n_in_mc = 1'b1; n_ld_left = 0; n_fl_left = 0;
      end else if (bus.pc_r || (m_in_mc && m_pend)) begin
        e_fde = 1'b1; e_fex = 1'b1; e_rt = 1'b1;
        n_fl_left = FC - 1; n_ld_left = 0; n_pend = 1'b0;
      end else if (m_fl_left > 0) begin
        e_fde = 1'b1; e_fex = 1'b1; n_fl_left = m_fl_left - 1;
      end else if (m_ld_left > 0) begin
        e_sfe = 1'b1; e_sde = 1'b1; e_fex = 1'b1; n_ld_left = m_ld_left - 1;
      end else if (lu) begin
        e_sfe = 1'b1; e_sde = 1'b1; e_fex = 1'b1; n_ld_left = LSC - 1;
      end
    end
  endtask

  task automatic check_outputs();
    chk("fwd_rs1", 32'(bus.fwd_rs1), 32'(e_f1));
    chk("fwd_rs2", 32'(bus.fwd_rs2), 32'(e_f2));
    chk("stall_fe", 32'(bus.stall_fe), 32'(e_sfe));
    chk("stall_de", 32'(bus.stall_de), 32'(e_sde));
    chk("stall_ex", 32'(bus.stall_ex), 32'(e_sex));
    chk("flush_de", 32'(bus.flush_de), 32'(e_fde));
    chk("flush_ex", 32'(bus.flush_ex), 32'(e_fex));
    chk("redirect_take", 32'(bus.redirect_take), 32'(e_rt));
`ifdef HAZARD_PERF_EN
    chk("stall_cnt", bus.stall_cnt, m_scnt[31:0]);
    chk("flush_cnt", bus.flush_cnt, m_fcnt[31:0]);
`else
    chk("stall_cnt", bus.stall_cnt, 32'd0);
    chk("flush_cnt", bus.flush_cnt, 32'd0);
`endif
  endtask

  // One clock cycle: compare at the falling edge, then advance the model
  task automatic step();
    @(negedge clk);
    model_eval();
    check_outputs();
    m_ld_left = n_ld_left; m_fl_left = n_fl_left; m_pend = n_pend; m_in_mc = n_in_mc;
    if (e_sfe && m_scnt != 64'hFFFF_FFFF) m_scnt++;
    if (e_fde && m_fcnt != 64'hFFFF_FFFF) m_fcnt++;
    @(posedge clk);
    #1;
  endtask

  // Assert reset away from the clock edge and check outputs drop at once
  task automatic reset_mid();
    rst = 1'b0;
    #1;
    model_reset();
    model_eval();
    check_outputs();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic set_idle();
    bus.rs1_de = 5'd0; bus.rs2_de = 5'd0; bus.rs1_ex = 5'd0; bus.rs2_ex = 5'd0;
    bus.rd_ex = 5'd0; bus.mem_read_ex = 1'b0; bus.rd_me = 5'd0;
    bus.reg_write_me = 1'b0; bus.mem_read_me = 1'b0; bus.rd_wb = 5'd0;
    bus.reg_write_wb = 1'b0; bus.pc_r = 1'b0; bus.ex_busy = 1'b0;
  endtask

  initial begin
    // Reset with active-looking inputs: every output must still be 0
    rst = 1'b0;
    set_idle();
    bus.rd_me = 5'd5; bus.reg_write_me = 1'b1; bus.rs1_ex = 5'd5;
    bus.mem_read_ex = 1'b1; bus.rd_ex = 5'd3; bus.rs1_de = 5'd3; bus.pc_r = 1'b1;
    #2;
    model_reset();
    model_eval();
    check_outputs();
    @(posedge clk);
    #1;
    rst = 1'b1;
    set_idle();

    // Forwarding: memory stage beats writeback, then writeback alone
    bus.rd_me = 5'd5; bus.reg_write_me = 1'b1; bus.rs1_ex = 5'd5;
    bus.rd_wb = 5'd5; bus.reg_write_wb = 1'b1;
    step();
    chk("fwd_mem_prio", 32'(bus.fwd_rs1), 32'd1);
    bus.rd_me = 5'd0;
    step();
    chk("fwd_wb_x0me", 32'(bus.fwd_rs1), 32'd2);
    bus.rd_me = 5'd5; bus.mem_read_me = 1'b1; bus.rs2_ex = 5'd5;
    step();
    set_idle();

    // Load-use of length 2, then x0 destination gives no stall
    bus.mem_read_ex = 1'b1; bus.rd_ex = 5'd7; bus.rs2_de = 5'd7;
    step();
    step();
    bus.mem_read_ex = 1'b0;
    step();
    step();
    bus.mem_read_ex = 1'b1; bus.rd_ex = 5'd0; bus.rs2_de = 5'd0;
    step();
    set_idle();

    // Single-cycle redirect pulse, two flush cycles
    bus.pc_r = 1'b1;
    step();
    bus.pc_r = 1'b0;
    step();
    step();

    // Redirect on the second load-stall cycle aborts the stall
    bus.mem_read_ex = 1'b1; bus.rd_ex = 5'd9; bus.rs1_de = 5'd9;
    step();
    bus.pc_r = 1'b1;
    step();
    set_idle();
    step();
    step();

    // Busy for 4 cycles with a redirect in cycle 2, released in cycle 5
    bus.ex_busy = 1'b1;
    step();
    bus.pc_r = 1'b1;
    step();
    bus.pc_r = 1'b0;
    step();
    step();
    bus.ex_busy = 1'b0;
    step();
    step();
    step();

    // Reset in the middle of FLUSH
    bus.pc_r = 1'b1;
    step();
    bus.pc_r = 1'b0;
    reset_mid();
    step();

    // Reset in MC_STALL with a pending redirect: the redirect is lost
    bus.ex_busy = 1'b1; bus.pc_r = 1'b1;
    step();
    bus.pc_r = 1'b0;
    reset_mid();
    bus.ex_busy = 1'b0;
    step();
    step();

    // Performance scenario: 3 load stalls of 2 cycles, 1 redirect of 2 cycles
    reset_mid();
    for (int k = 0; k < 3; k++) begin
      bus.mem_read_ex = 1'b1; bus.rd_ex = 5'd4; bus.rs1_de = 5'd4;
      step();
      step();
      bus.mem_read_ex = 1'b0;
      step();
    end
    bus.pc_r = 1'b1;
    step();
    bus.pc_r = 1'b0;
    step();
`ifdef HAZARD_PERF_EN
    chk("perf_stall_total", bus.stall_cnt, 32'd6);
    chk("perf_flush_total", bus.flush_cnt, 32'd2);
`else
    chk("perf_stall_tied", bus.stall_cnt, 32'd0);
    chk("perf_flush_tied", bus.flush_cnt, 32'd0);
`endif

    // Randomized cycles with small register indices to provoke collisions
    for (int i = 0; i < 400; i++) begin
      bus.rs1_de       = 5'($urandom_range(0, 3));
      bus.rs2_de       = 5'($urandom_range(0, 3));
      bus.rs1_ex       = 5'($urandom_range(0, 3));
      bus.rs2_ex       = 5'($urandom_range(0, 3));
      bus.rd_ex        = 5'($urandom_range(0, 3));
      bus.rd_me        = 5'($urandom_range(0, 3));
      bus.rd_wb        = 5'($urandom_range(0, 3));
      bus.mem_read_ex  = 1'($urandom_range(0, 1));
      bus.reg_write_me = 1'($urandom_range(0, 1));
      bus.mem_read_me  = 1'($urandom_range(0, 1));
      bus.reg_write_wb = 1'($urandom_range(0, 1));
      bus.ex_busy      = ($urandom_range(0, 4) == 0);
      bus.pc_r         = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 79) == 0) begin
        reset_mid();
      end else begin
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
